// File: rtl/async_ram_responder.sv
// Word-addressed RAM responder with fixed read latency and a wait_n handshake.
// Optional periodic refresh stalls are enabled by defining ASYNC_MEM_REFRESH_EN.
module async_ram_responder #(
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned READ_LATENCY   = 2,
  parameter int unsigned REFRESH_PERIOD = 64,
  parameter int unsigned REFRESH_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_mem_rd,
  input  logic                  io_mem_wr,
  input  logic [ADDR_WIDTH-1:0] io_mem_addr,
  input  logic [DATA_WIDTH-1:0] io_mem_din,
  output logic [DATA_WIDTH-1:0] io_mem_dout,
  output logic                  io_mem_wait_n,
  output logic                  io_mem_valid
);

  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0]  LAT_LOAD = 4'(READ_LATENCY - 1);

  if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_latency
    $error("READ_LATENCY must be in 1..15");
  end
  if (REFRESH_PERIOD < 2 || REFRESH_CYCLES < 1) begin : g_bad_refresh
    $error("REFRESH_PERIOD must be >= 2 and REFRESH_CYCLES >= 1");
  end

`ifdef ASYNC_MEM_REFRESH_EN
  typedef enum logic [1:0] {IDLE, READ, REFRESH} state_e;

  localparam int unsigned     PER_W    = $clog2(REFRESH_PERIOD);
  localparam int unsigned     REF_W    = $clog2(REFRESH_CYCLES + 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(REFRESH_PERIOD - 1);
  localparam logic [REF_W-1:0] REF_LOAD = REF_W'(REFRESH_CYCLES - 1);

  logic [PER_W-1:0] per_cnt_q;
  logic [REF_W-1:0] ref_cnt_q;
  logic             pend_q;
`else
  typedef enum logic {IDLE, READ} state_e;
`endif

  state_e                state_q;
  logic [3:0]            lat_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  rd_acc;
  logic                  wr_acc;

  always_comb begin
`ifdef ASYNC_MEM_REFRESH_EN
    io_mem_wait_n = (state_q == IDLE) && !pend_q;
`else
    io_mem_wait_n = (state_q == IDLE);
`endif
    rd_acc = io_mem_rd && io_mem_wait_n;
    // A simultaneous read wins, so the write is dropped.
    wr_acc = io_mem_wr && !io_mem_rd && io_mem_wait_n;
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (!reset && wr_acc) begin
      mem_q[io_mem_addr] <= io_mem_din;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      lat_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      dout_q  <= '0;
`ifdef ASYNC_MEM_REFRESH_EN
      per_cnt_q <= '0;
      ref_cnt_q <= '0;
      pend_q    <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
`ifdef ASYNC_MEM_REFRESH_EN
      per_cnt_q <= (per_cnt_q == PER_LAST) ? '0 : per_cnt_q + PER_W'(1);
`endif
      case (state_q)
        IDLE: begin
          if (rd_acc) begin
            addr_q  <= io_mem_addr;
            lat_q   <= LAT_LOAD;
            state_q <= READ;
            // Latency of one means the valid cycle directly follows acceptance.
            if (READ_LATENCY == 1) begin
              valid_q <= 1'b1;
              dout_q  <= mem_q[io_mem_addr];
            end
          end
`ifdef ASYNC_MEM_REFRESH_EN
          else if (pend_q) begin
            state_q   <= REFRESH;
            ref_cnt_q <= REF_LOAD;
          end
`endif
        end
        READ: begin
          if (valid_q) begin
            state_q <= IDLE;
          end else begin
            lat_q <= lat_q - 4'd1;
            if (lat_q == 4'd1) begin
              valid_q <= 1'b1;
              dout_q  <= mem_q[addr_q];
            end
          end
        end
`ifdef ASYNC_MEM_REFRESH_EN
        REFRESH: begin
          if (ref_cnt_q == '0) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
          end else begin
            ref_cnt_q <= ref_cnt_q - REF_W'(1);
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
`ifdef ASYNC_MEM_REFRESH_EN
      // Placed after the case so a new request outranks a same-edge clear.
      if (per_cnt_q == PER_LAST) begin
        pend_q <= 1'b1;
      end
`endif
    end
  end

  assign io_mem_valid = valid_q;
  assign io_mem_dout  = dout_q;

endmodule

// File: tb/tb_async_ram_responder.sv
// Directed self-checking bench for async_ram_responder (READ_LATENCY = 2).
// Refresh scenarios are exercised when ASYNC_MEM_REFRESH_EN is defined.
module tb_async_ram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd;
  logic        wr;
  logic [6:0]  addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        wait_n;
  logic        valid;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  async_ram_responder #(
    .ADDR_WIDTH    (7),
    .DATA_WIDTH    (16),
    .READ_LATENCY  (2),
    .REFRESH_PERIOD(64),
    .REFRESH_CYCLES(4)
  ) dut (
    .clock        (clk),
    .reset        (rst),
    .io_mem_rd    (rd),
    .io_mem_wr    (wr),
    .io_mem_addr  (addr),
    .io_mem_din   (din),
    .io_mem_dout  (dout),
    .io_mem_wait_n(wait_n),
    .io_mem_valid (valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!wait_n && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!wait_n) check({tag, "_ready"}, 32'(wait_n), 32'd1);
  endtask

  task automatic do_write(input logic [6:0] a, input logic [15:0] d);
    wait_ready("wr");
    addr = a; din = d; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  // Issues a read (optionally with wr also high); returns edges to valid,
  // wait_n-low cycles seen, and the data in the valid cycle.
  task automatic do_read(input logic [6:0] a, input logic both,
                         output int lat, output int low, output logic [15:0] d);
    bit seen = 0;
    lat = 0; low = 0; d = '0;
    wait_ready("rd");
    addr = a; rd = 1'b1; wr = both;
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (!wait_n) low++;
      if (valid) begin
        seen = 1; lat = i; d = dout;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; din = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_dout", 32'(dout), 32'd0);
    check("reset_wait_n", 32'(wait_n), 32'd1);
    @(posedge clk); #1;
  endtask

`ifdef ASYNC_MEM_REFRESH_EN
  int unsigned cyc;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
`endif

  initial begin
    int lat, low, vcnt, wcnt, dbl, vcyc;
    logic [15:0] d;
    logic prev;

    apply_reset();

`ifdef ASYNC_MEM_REFRESH_EN
    // cyc now equals the cycle index since reset release (1).
    do_write(7'h7E, 16'h0000);
    low = 0; vcyc = 0; wr = 1'b1;
    while (cyc < 120) begin
      @(negedge clk);
      if (!wait_n) begin
        if (low == 0) vcyc = int'(cyc);
        low++;
        addr = 7'h7E; din = 16'hDEAD;
      end else begin
        addr = 7'h7D; din = cyc[15:0];
      end
      @(posedge clk); #1;
    end
    wr = 1'b0;
    check("ref_low_cycles", 32'(low), 32'd5);
    check("ref_first_low", 32'(vcyc), 32'd64);
    do_read(7'h7E, 1'b0, lat, low, d);
    check("ref_blocked_wr", 32'(d), 32'h0000);
    do_read(7'h7D, 1'b0, lat, low, d);
    check("ref_last_wr", 32'(d), 32'h0077);

    // Pending arrives during the valid cycle (192); refresh must follow the read.
    while (cyc < 190) begin @(posedge clk); #1; end
    addr = 7'h7D; rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0; low = 0; vcyc = 0; d = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (valid) begin vcyc = int'(cyc); d = dout; end
      if (!wait_n) low++;
      @(posedge clk); #1;
    end
    check("defer_valid_cycle", 32'(vcyc), 32'd192);
    check("defer_dout", 32'(d), 32'h0077);
    check("defer_low_cycles", 32'(low), 32'd7);
`else
    // Write then read back.
    do_write(7'h05, 16'hBEEF);
    do_read(7'h05, 1'b0, lat, low, d);
    check("wr_rd_latency", 32'(lat), 32'd2);
    check("wr_rd_dout", 32'(d), 32'hBEEF);
    check("wr_rd_wait_low", 32'(low), 32'd2);
    @(negedge clk);
    check("post_valid", 32'(valid), 32'd0);
    check("post_wait_n", 32'(wait_n), 32'd1);
    @(posedge clk); #1;

    // Back-to-back writes, one per cycle, including the top address.
    wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      addr = (i == 4) ? 7'h7F : 7'(32'h20 + i);
      din  = 16'(32'h5000 + i);
      @(negedge clk);
      check("b2b_wait_n", 32'(wait_n), 32'd1);
      @(posedge clk); #1;
    end
    wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_read((i == 4) ? 7'h7F : 7'(32'h20 + i), 1'b0, lat, low, d);
      check("b2b_readback", 32'(d), 32'h5000 + 32'(i));
    end

    // Read held high: one response per 3-cycle transaction.
    do_write(7'h00, 16'h1111);
    do_write(7'h01, 16'h2222);
    addr = 7'h00; rd = 1'b1;
    vcnt = 0; wcnt = 0; dbl = 0; prev = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid) begin
        vcnt++;
        check("hold_dout", 32'(dout), 32'h1111);
      end
      if (valid && prev) dbl++;
      prev = valid;
      if (wait_n) wcnt++;
      @(posedge clk); #1;
    end
    rd = 1'b0;
    check("hold_valids", 32'(vcnt), 32'd4);
    check("hold_accepts", 32'(wcnt), 32'd4);
    check("hold_double", 32'(dbl), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (valid) vcnt++;
      @(posedge clk); #1;
    end
    check("hold_tail", 32'(vcnt), 32'd4);

    // Simultaneous rd and wr: read wins, storage untouched.
    do_write(7'h10, 16'h1234);
    din = 16'hAAAA;
    do_read(7'h10, 1'b1, lat, low, d);
    check("rdwr_dout", 32'(d), 32'h1234);
    do_read(7'h10, 1'b0, lat, low, d);
    check("rdwr_storage", 32'(d), 32'h1234);

    // Reset one edge after read acceptance aborts the read.
    addr = 7'h05; rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_wait_n", 32'(wait_n), 32'd1);
    check("abort_dout", 32'(dout), 32'd0);
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (valid) vcnt++;
      @(negedge clk);
    end
    check("abort_no_valid", 32'(vcnt), 32'd0);
    @(posedge clk); #1;
    do_read(7'h05, 1'b0, lat, low, d);
    check("mem_kept_over_reset", 32'(d), 32'hBEEF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
